// File: rtl/chain_mgr_pkg.sv
// rtl/chain_mgr_pkg.sv - shared constants, state type and helper functions for the chain manager
package chain_mgr_pkg;

  localparam int NUM_PORTS = 16;
  localparam int NUM_PRIO  = 8;
  localparam int NUM_Q     = NUM_PORTS * NUM_PRIO;
  localparam int PORT_W    = 4;
  localparam int PRIO_W    = 3;
  localparam int QW        = PORT_W + PRIO_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  // Queue index: port in the upper bits so one port's eight priorities are contiguous.
  function automatic logic [QW-1:0] queue_index(input logic [PORT_W-1:0] port,
                                                input logic [PRIO_W-1:0] prio);
    return {port, prio};
  endfunction

  // Cells needed for a packet of the given byte length (ceiling division).
  function automatic logic [3:0] cells_needed(input logic [7:0] size,
                                              input int unsigned cell_bytes);
    int unsigned n;
    n = (32'(size) + cell_bytes - 32'd1) / cell_bytes;
    return n[3:0];
  endfunction

endpackage

// File: rtl/chain_prio_sel.sv
// rtl/chain_prio_sel.sv - picks the lowest-index (highest) priority with a non-empty queue
module chain_prio_sel
  import chain_mgr_pkg::*;
(
  input  logic [NUM_PRIO-1:0] flags,
  output logic [PRIO_W-1:0]   prio,
  output logic                found
);

  // Scan from the lowest priority upward so the last hit (index 0 side) wins.
  always_comb begin
    prio  = '0;
    found = 1'b0;
    for (int i = NUM_PRIO - 1; i >= 0; i--) begin
      if (flags[i]) begin
        found = 1'b1;
        prio  = PRIO_W'(i);
      end
    end
  end

endmodule

// File: rtl/chain_manager.sv
// rtl/chain_manager.sv - linked-list cell manager for the packet SRAM; CHAIN_MGR_DROP_CNT_EN adds drop_cnt
module chain_manager
  import chain_mgr_pkg::*;
#(
  parameter int NUM_CELLS  = 64,
  parameter int CELL_BYTES = 32,
  localparam int AW        = $clog2(NUM_CELLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wea,
  input  logic [7:0]    w_size,
  input  logic [2:0]    w_priority,
  input  logic [3:0]    dest_port,
  input  logic          rea,
  input  logic [3:0]    out_port,
  output logic          ready,
  output logic          wr_cell_vld,
  output logic [AW-1:0] wr_cell_addr,
  output logic          w_ack,
  output logic          w_drop,
  output logic          rd_cell_vld,
  output logic [AW-1:0] rd_cell_addr,
  output logic          r_done,
  output logic [7:0]    r_size,
  output logic          r_empty,
  output logic [AW:0]   free_cnt
`ifdef CHAIN_MGR_DROP_CNT_EN
  ,
  output logic [15:0]   drop_cnt
`endif
);

  state_t state, state_next;

  logic [AW-1:0] chain     [NUM_CELLS];
  logic [7:0]    len       [NUM_CELLS];
  logic [AW-1:0] q_head    [NUM_Q];
  logic [AW-1:0] q_tail    [NUM_Q];
  logic [7:0]    queue_num [NUM_Q];

  logic [AW-1:0] free_head, free_tail;
  logic [AW-1:0] cur, prev;
  logic [3:0]    cnt, n_cells;
  logic [QW-1:0] q_sel;

  logic [QW-1:0]       w_q, r_q;
  logic [3:0]          w_n;
  logic                w_req, w_reject, r_req, last;
  logic [NUM_PRIO-1:0] prio_flags;
  logic [PRIO_W-1:0]   sel_prio;
  logic                sel_found;
  logic [AW-1:0]       r_head;
  logic [7:0]          r_len;

  // Request decode and per-cycle helpers shared by the FSM and datapath.
  always_comb begin
    ready    = (state == ST_IDLE);
    w_q      = queue_index(dest_port, w_priority);
    w_n      = cells_needed(w_size, CELL_BYTES);
    w_req    = ready && wea;
    w_reject = (w_size == 8'd0) || ((AW+1)'(w_n) > free_cnt);
    r_req    = ready && rea && !wea;
    r_q      = queue_index(out_port, sel_prio);
    r_head   = q_head[r_q];
    r_len    = len[r_head];
    last     = (cnt == n_cells - 4'd1);
  end

  // Non-empty flags for the eight priorities of the requested output port.
  always_comb begin
    prio_flags = '0;
    for (int p = 0; p < NUM_PRIO; p++) begin
      prio_flags[p] = (queue_num[queue_index(out_port, PRIO_W'(p))] != 8'd0);
    end
  end

  chain_prio_sel u_prio_sel (
    .flags (prio_flags),
    .prio  (sel_prio),
    .found (sel_found)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state logic; rejected or empty requests never leave IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (w_req) begin
          if (!w_reject) state_next = ST_WRITE;
        end else if (r_req && sel_found) begin
          state_next = ST_READ;
        end
      end
      ST_WRITE: if (last) state_next = ST_IDLE;
      ST_READ:  if (last) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Cell outputs come straight from state registers.
  always_comb begin
    wr_cell_vld  = (state == ST_WRITE);
    wr_cell_addr = free_head;
    w_ack        = wr_cell_vld && last;
    rd_cell_vld  = (state == ST_READ);
    rd_cell_addr = cur;
    r_done       = rd_cell_vld && last;
  end

  // Free list, chain links, queue counters and status pulses (all reset).
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CELLS; i++) chain[i] <= AW'(i + 1);
      for (int j = 0; j < NUM_Q; j++) queue_num[j] <= 8'd0;
      free_head <= '0;
      free_tail <= AW'(NUM_CELLS - 1);
      free_cnt  <= (AW+1)'(NUM_CELLS);
      cur       <= '0;
      prev      <= '0;
      cnt       <= 4'd0;
      n_cells   <= 4'd0;
      q_sel     <= '0;
      w_drop    <= 1'b0;
      r_empty   <= 1'b0;
      r_size    <= 8'd0;
    end else begin
      w_drop  <= 1'b0;
      r_empty <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (w_req) begin
            if (w_reject) begin
              w_drop <= 1'b1;
            end else begin
              q_sel   <= w_q;
              n_cells <= w_n;
              cnt     <= 4'd0;
            end
          end else if (r_req) begin
            if (!sel_found) begin
              r_empty <= 1'b1;
            end else begin
              q_sel   <= r_q;
              cur     <= r_head;
              n_cells <= cells_needed(r_len, CELL_BYTES);
              r_size  <= r_len;
              cnt     <= 4'd0;
            end
          end
        end
        ST_WRITE: begin
          free_head <= chain[free_head];
          free_cnt  <= free_cnt - (AW+1)'(1);
          prev      <= free_head;
          cnt       <= cnt + 4'd1;
          if (cnt == 4'd0) begin
            if (queue_num[q_sel] != 8'd0) chain[q_tail[q_sel]] <= free_head;
          end else begin
            chain[prev] <= free_head;
          end
          if (last) queue_num[q_sel] <= queue_num[q_sel] + 8'd1;
        end
        ST_READ: begin
          cur <= chain[cur];
          // An empty free list has a meaningless tail, so the cell becomes the new head.
          if (free_cnt == '0) free_head <= cur;
          else                chain[free_tail] <= cur;
          free_tail <= cur;
          free_cnt  <= free_cnt + (AW+1)'(1);
          cnt       <= cnt + 4'd1;
          if (last) queue_num[q_sel] <= queue_num[q_sel] - 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Packet lengths and queue head/tail pointers are only meaningful behind queue_num, so no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      case (state)
        ST_IDLE: begin
          if (w_req && !w_reject) len[free_head] <= w_size;
        end
        ST_WRITE: begin
          if (cnt == 4'd0 && queue_num[q_sel] == 8'd0) q_head[q_sel] <= free_head;
          if (last) q_tail[q_sel] <= free_head;
        end
        ST_READ: begin
          if (last) q_head[q_sel] <= chain[cur];
        end
        default: ;
      endcase
    end
  end

`ifdef CHAIN_MGR_DROP_CNT_EN
  // Saturating count of rejected writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_cnt <= 16'd0;
    end else if (w_req && w_reject && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_chain_manager.sv
// tb/tb_chain_manager.sv - self-checking bench for chain_manager with a FIFO-based reference model
module tb_chain_manager;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          wea;
  logic [7:0]    w_size;
  logic [2:0]    w_priority;
  logic [3:0]    dest_port;
  logic          rea;
  logic [3:0]    out_port;
  logic          ready;
  logic          wr_cell_vld;
  logic [AW-1:0] wr_cell_addr;
  logic          w_ack;
  logic          w_drop;
  logic          rd_cell_vld;
  logic [AW-1:0] rd_cell_addr;
  logic          r_done;
  logic [7:0]    r_size;
  logic          r_empty;
  logic [AW:0]   free_cnt;
`ifdef CHAIN_MGR_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  chain_manager dut (
    .clk          (clk),
    .rst          (rst),
    .wea          (wea),
    .w_size       (w_size),
    .w_priority   (w_priority),
    .dest_port    (dest_port),
    .rea          (rea),
    .out_port     (out_port),
    .ready        (ready),
    .wr_cell_vld  (wr_cell_vld),
    .wr_cell_addr (wr_cell_addr),
    .w_ack        (w_ack),
    .w_drop       (w_drop),
    .rd_cell_vld  (rd_cell_vld),
    .rd_cell_addr (rd_cell_addr),
    .r_done       (r_done),
    .r_size       (r_size),
    .r_empty      (r_empty),
`ifdef CHAIN_MGR_DROP_CNT_EN
    .drop_cnt     (drop_cnt),
`endif
    .free_cnt     (free_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int free_q[$];
  int mq_cells[128][$];
  int mq_size[128][$];
  int exp_addr[$];
  int exp_r_size = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    free_q.delete();
    for (int i = 0; i < 64; i++) free_q.push_back(i);
    for (int q = 0; q < 128; q++) begin
      mq_cells[q].delete();
      mq_size[q].delete();
    end
    exp_addr.delete();
    exp_r_size = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst_free_cnt", free_cnt, 64);
    check("rst_ready", ready, 1);
    check("rst_wr_vld", wr_cell_vld, 0);
    check("rst_rd_vld", rd_cell_vld, 0);
    check("rst_w_drop", w_drop, 0);
    check("rst_r_empty", r_empty, 0);
    check("rst_r_size", r_size, 0);
  endtask

  task automatic do_write(input int port, input int prio, input int size, input bit with_rea);
    int n, q, c;
    bit drop;
    n = (size + 31) / 32;
    q = port * 8 + prio;
    drop = (size == 0) || (n > free_q.size());
    if (!drop) begin
      for (int k = 0; k < n; k++) begin
        c = free_q.pop_front();
        exp_addr.push_back(c);
        mq_cells[q].push_back(c);
      end
      mq_size[q].push_back(size);
    end
    check("wr_ready_before", ready, 1);
    wea = 1'b1; w_size = 8'(size); w_priority = 3'(prio); dest_port = 4'(port);
    rea = with_rea; out_port = 4'(port);
    @(posedge clk); #1;
    wea = 1'b0; rea = 1'b0;
    @(negedge clk);
    if (drop) begin
      check("w_drop", w_drop, 1);
      check("drop_no_wr_vld", wr_cell_vld, 0);
      check("drop_ready", ready, 1);
    end else begin
      for (int k = 0; k < n; k++) begin
        check("wr_vld", wr_cell_vld, 1);
        check("wr_addr", wr_cell_addr, exp_addr.pop_front());
        check("w_ack", w_ack, (k == n - 1));
        check("wr_no_rd_vld", rd_cell_vld, 0);
        @(negedge clk);
      end
      check("wr_ready_after", ready, 1);
      check("wr_vld_after", wr_cell_vld, 0);
    end
    check("wr_free_cnt", free_cnt, free_q.size());
  endtask

  task automatic do_read(input int port);
    int q, n, c, sz;
    bit empty;
    empty = 1'b1;
    q = 0;
    for (int p = 0; p < 8; p++) begin
      if (empty && mq_size[port * 8 + p].size() != 0) begin
        empty = 1'b0;
        q = port * 8 + p;
      end
    end
    n = 0;
    if (!empty) begin
      sz = mq_size[q].pop_front();
      exp_r_size = sz;
      n = (sz + 31) / 32;
      for (int k = 0; k < n; k++) begin
        c = mq_cells[q].pop_front();
        exp_addr.push_back(c);
        free_q.push_back(c);
      end
    end
    check("rd_ready_before", ready, 1);
    rea = 1'b1; out_port = 4'(port);
    @(posedge clk); #1;
    rea = 1'b0;
    @(negedge clk);
    if (empty) begin
      check("r_empty", r_empty, 1);
      check("empty_no_rd_vld", rd_cell_vld, 0);
      check("empty_ready", ready, 1);
      check("empty_r_size", r_size, exp_r_size);
    end else begin
      check("r_size", r_size, exp_r_size);
      for (int k = 0; k < n; k++) begin
        check("rd_vld", rd_cell_vld, 1);
        check("rd_addr", rd_cell_addr, exp_addr.pop_front());
        check("r_done", r_done, (k == n - 1));
        check("rd_no_wr_vld", wr_cell_vld, 0);
        @(negedge clk);
      end
      check("rd_ready_after", ready, 1);
      check("r_empty_clear", r_empty, 0);
    end
    check("rd_free_cnt", free_cnt, free_q.size());
  endtask

  initial begin
    rst = 1'b0; wea = 1'b0; rea = 1'b0;
    w_size = 8'd0; w_priority = 3'd0; dest_port = 4'd0; out_port = 4'd0;
    @(posedge clk); #1;
    apply_reset();

    // 1: first write takes cells 0 and 1
    do_write(0, 0, 60, 1'b0);
    check("t1_free_cnt", free_cnt, 62);

    // 2: second packet on the same queue, then two reads in order
    do_write(0, 0, 62, 1'b0);
    do_read(0);
    do_read(0);
    check("t2_free_cnt", free_cnt, 64);

    // 3: priority 2 beats priority 5 on the same port
    do_write(3, 5, 40, 1'b0);
    do_write(3, 2, 20, 1'b0);
    do_read(3);
    check("t3_r_size", r_size, 20);
    do_read(3);

    // 5: empty port read and zero-length write
    do_read(7);
    check("t5_free_cnt", free_cnt, 64);
    do_write(2, 1, 0, 1'b0);

    // 4: fill the whole SRAM, overflow, then recycle through an empty free list
    apply_reset();
    for (int i = 0; i < 8; i++) do_write(i, 0, 255, 1'b0);
    check("t4_free_cnt_zero", free_cnt, 0);
    do_write(9, 0, 255, 1'b0);
`ifdef CHAIN_MGR_DROP_CNT_EN
    check("t4_drop_cnt", drop_cnt, 1);
`endif
    do_read(0);
    do_write(10, 4, 255, 1'b0);
    do_read(10);
    do_read(1);

    // 7a: simultaneous write and read request; only the write runs
    apply_reset();
    do_write(5, 3, 100, 1'b0);
    do_write(5, 1, 33, 1'b1);
    do_read(5);
    do_read(5);
    do_read(5);

    // 7b: reset in the middle of a write
    wea = 1'b1; w_size = 8'd255; w_priority = 3'd0; dest_port = 4'd4;
    @(posedge clk); #1;
    wea = 1'b0;
    @(negedge clk);
    check("t7_mid_wr_vld", wr_cell_vld, 1);
    @(negedge clk);
    check("t7_mid_free_cnt", free_cnt, free_q.size() - 1);
    apply_reset();
    do_read(4);
    do_write(4, 0, 10, 1'b0);

    // 6: recycling from a fresh reset; freed cells 0,1 come back after 2..63
    apply_reset();
    do_write(0, 0, 64, 1'b0);
    do_read(0);
    for (int i = 0; i < 31; i++) do_write(i % 16, 1, 50, 1'b0);
    check("t6_free_cnt", free_cnt, 2);
    do_write(6, 6, 40, 1'b0);
    check("t6_free_cnt_zero", free_cnt, 0);
    do_read(1);
    do_read(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
